fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
Read-side controller of the dual-clock FIFO, running entirely in the read clock domain. It is the counterpart of the write-side controller. It does the following:
- Synchronises the write-domain Gray write pointer into read_clk.
- Maintains the binary and Gray read pointers.
- Generates the memory read address and read enable.
- Produces the empty, almost_empty, level and underflow status.
Its Gray read pointer output feeds the existing read-pointer synchroniser on the write side.

Parameters:
address, 3, FIFO address width; depth = 2**address; pointers are address+1 bits
ALMOST_EMPTY, 1, almost_empty asserts when level <= ALMOST_EMPTY (range 0..2**address-1)

Ports:
read_clk  input  1  read-domain clock; all logic on its rising edge
read_rst  input  1  reset, synchronous, active-high
read_en  input  1  read request from the consumer
write_ptr  input  address+1  Gray write pointer from the write domain (asynchronous to read_clk)
read_fire  output  1  combinational read_en & ~empty; memory read enable
read_addr  output  address  memory read address = rbin[address-1:0]
read_ptr  output  address+1  registered Gray read pointer, sent to the write domain
empty  output  1  registered empty flag
almost_empty  output  1  registered, level <= ALMOST_EMPTY
read_level  output  address+1  registered occupancy seen from the read side, 0..2**address
underflow  output  1  registered one-cycle pulse on a read attempt while empty

Behaviour:
- Clocking and reset: single clock read_clk; reset read_rst is synchronous and active-high. Every register updates on the rising edge of read_clk.
- Reset values (next edge with read_rst=1, regardless of other inputs):
  - rbin=0, read_ptr=0, both sync stages=0
  - empty=1, almost_empty=1, read_level=0, underflow=0
  - Consequently read_addr=0 and read_fire=0.
- Write-pointer synchroniser: two flops, tmp <= write_ptr, then wsync <= tmp. No logic between the stages. Only wsync is used downstream.
- Read pointer:
  - rbin_next = rbin + read_fire, modulo 2**(address+1).
  - rgray_next = (rbin_next>>1) ^ rbin_next.
  - rbin <= rbin_next; read_ptr <= rgray_next.
  - read_ptr changes by exactly one bit per fire.
- Empty: empty <= (rgray_next == wsync). This is a full-width Gray compare that includes the MSB wrap bit.
- Level:
  - wbin = gray-to-binary(wsync).
  - read_level <= (wbin - rbin_next) mod 2**(address+1).
  - almost_empty <= (that same value <= ALMOST_EMPTY).
- Latency:
  - A write_ptr change meeting setup at edge N is captured in tmp at N and in wsync at N+1. empty, read_level and almost_empty reflect it at edge N+2.
  - A fire at edge M updates read_ptr, read_addr, empty and read_level at edge M.
- Handshake:
  - Data for read_addr is consumed when read_fire=1 at a rising edge.
  - Back-to-back fires are allowed every cycle while empty=0.
  - The consumer may hold read_en high continuously; fires stop automatically when empty.
- Underflow: underflow <= read_en & empty. It is a pulse, not sticky. The pointer is unchanged on underflow.
- Wrap-around: rbin rolls from 2**(address+1)-1 to 0 with no special case. The Gray pointer rolls with a single-bit change (address=3: 1000 -> 0000). Level arithmetic is modulo, so it stays correct across the wrap.
- Simultaneous events:
  - A fire on the last entry coinciding with a new write arriving in wsync gives empty=0 and level=1.
  - Compare against rgray_next, never the old pointer.
- Pessimism: empty and level are conservative, because the write pointer lags by 2 cycles. A stale wsync can never cause a read past written data.
- Reset mid-operation:
  - All state returns to reset values at the next edge, even with read_en=1.
  - If write_ptr is non-zero after reset, empty falls 3 edges later as the synchroniser refills.
  - The system requirement that both domains reset together is the integrator's responsibility.

Decomposition:
- Package fifo_pkg holds:
  - default ADDRESS constant
  - bin2gray and gray2bin functions parameterised on width
  - pointer typedef of width address+1 (shared with the write controller)
- One natural sub-module: sync_write_ptr_in_read_clk. It is the 2-flop Gray synchroniser with synchronous active-high reset and ports write_ptr, read_rst, read_clk, sync_write_ptr.

Test Plan (address=3, ALMOST_EMPTY=1):
1. Reset: read_rst=1 for 2 cycles, write_ptr=0000, read_en=1 -> empty=1, almost_empty=1, read_ptr=0000, read_addr=0, read_level=0, read_fire=0 throughout.
2. Single write/read: write_ptr 0000->0001 at edge N -> empty=0 and read_level=1 at edge N+2. Then read_en for 1 cycle -> read_fire=1, then read_ptr=0001, read_addr=1, empty=1, read_level=0.
3. Full drain: write_ptr=1100 (binary 8), held -> read_level=8, almost_empty=0. Hold read_en -> exactly 8 fires. read_ptr sequence is 0001,0011,0010,0110,0111,0101,0100,1100. empty=1 after the 8th fire; almost_empty=1 when level<=1.
4. Underflow: empty=1, read_en=1 for 3 cycles -> read_fire=0, read_ptr unchanged, underflow=1 for each of those 3 cycles (delayed one edge), then 0.
5. Wrap: stream 20 single writes, each followed by a read -> rbin passes 15->0, read_ptr 1000->0000. After each write-read pair read_level=0 and empty=1, with no spurious level of 15/16.
6. Reset mid-operation: read_level=5, read_en=1, assert read_rst for one cycle -> next edge all outputs at reset values. With write_ptr held at gray(5)=0111 -> empty=0 and read_level=5 at edge 3 after read_rst deasserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width, pointer type and Gray/binary
// conversion helpers used by both the read and write controllers.
package fifo_pkg;

    localparam int ADDRESS = 3;

    typedef logic [ADDRESS:0] ptr_t;

    function automatic logic [31:0] width_mask(input int width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
        logic [31:0] v;
        v = b & width_mask(width);
        return (v >> 1) ^ v;
    endfunction

    // Prefix XOR from the MSB down; bits above width are masked to zero first.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] v;
        v = g & width_mask(width);
        for (int s = 1; s < 32; s = s * 2) begin
            v = v ^ (v >> s);
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_write_ptr_in_read_clk.sv
// Two-flop synchroniser bringing the Gray write pointer into the read clock.
module sync_write_ptr_in_read_clk #(
    parameter int WIDTH = 4
) (
    input  logic             read_clk,
    input  logic             read_rst,
    input  logic [WIDTH-1:0] write_ptr,
    output logic [WIDTH-1:0] sync_write_ptr
);

    logic [WIDTH-1:0] tmp_reg;
    logic [WIDTH-1:0] sync_reg;

    // No logic between stages: only one Gray bit may change per write.
    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            tmp_reg  <= '0;
            sync_reg <= '0;
        end else begin
            tmp_reg  <= write_ptr;
            sync_reg <= tmp_reg;
        end
    end

    assign sync_write_ptr = sync_reg;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointers, memory read
// port control and empty/level/underflow status in the read clock domain.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int address      = ADDRESS,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic               read_clk,
    input  logic               read_rst,
    input  logic               read_en,
    input  logic [address:0]   write_ptr,
    output logic               read_fire,
    output logic [address-1:0] read_addr,
    output logic [address:0]   read_ptr,
    output logic               empty,
    output logic               almost_empty,
    output logic [address:0]   read_level,
    output logic               underflow
);

    localparam int PW = address + 1;
    localparam logic [address:0] AE_THR = PW'(ALMOST_EMPTY);

    logic [address:0] rbin_reg;
    logic [address:0] rbin_next;
    logic [address:0] rgray_next;
    logic [address:0] read_ptr_reg;
    logic [address:0] wsync;
    logic [address:0] wbin;
    logic [address:0] level_next;
    logic [address:0] level_reg;
    logic             empty_reg;
    logic             almost_empty_reg;
    logic             underflow_reg;

    sync_write_ptr_in_read_clk #(
        .WIDTH(PW)
    ) u_sync (
        .read_clk       (read_clk),
        .read_rst       (read_rst),
        .write_ptr      (write_ptr),
        .sync_write_ptr (wsync)
    );

    assign read_fire = read_en & ~empty_reg;

    // Status is computed against the post-read pointer so a read of the last
    // entry and a newly visible write are both reflected at the same edge.
    always_comb begin
        rbin_next  = rbin_reg + {{address{1'b0}}, read_fire};
        rgray_next = PW'(bin2gray(32'(rbin_next), PW));
        wbin       = PW'(gray2bin(32'(wsync), PW));
        level_next = wbin - rbin_next;
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            rbin_reg         <= '0;
            read_ptr_reg     <= '0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            level_reg        <= '0;
            underflow_reg    <= 1'b0;
        end else begin
            rbin_reg         <= rbin_next;
            read_ptr_reg     <= rgray_next;
            empty_reg        <= (rgray_next == wsync);
            almost_empty_reg <= (level_next <= AE_THR);
            level_reg        <= level_next;
            underflow_reg    <= read_en & empty_reg;
        end
    end

    assign read_addr    = rbin_reg[address-1:0];
    assign read_ptr     = read_ptr_reg;
    assign empty        = empty_reg;
    assign almost_empty = almost_empty_reg;
    assign read_level   = level_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl (address=3, ALMOST_EMPTY=1) using
// vector tables, directed corner sequences and a count-based reference model.
module tb_fifo_read_ctrl;

    logic       read_clk;
    logic       read_rst;
    logic       read_en;
    logic [3:0] write_ptr;
    logic       read_fire;
    logic [2:0] read_addr;
    logic [3:0] read_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] read_level;
    logic       underflow;

    fifo_read_ctrl #(
        .address      (3),
        .ALMOST_EMPTY (1)
    ) dut (
        .read_clk     (read_clk),
        .read_rst     (read_rst),
        .read_en      (read_en),
        .write_ptr    (write_ptr),
        .read_fire    (read_fire),
        .read_addr    (read_addr),
        .read_ptr     (read_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .read_level   (read_level),
        .underflow    (underflow)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    int checks = 0;
    int errors = 0;

    // Model: total writes issued, total reads done, and the write count as it
    // appears one and two edges later in the read domain.
    int   w_count = 0;
    int   m_r     = 0;
    int   m_tmp   = 0;
    int   m_ws    = 0;
    int   m_level = 0;
    logic m_empty = 1'b1;
    logic m_uf    = 1'b0;
    logic m_valid = 1'b0;
    logic last_fire;

    typedef struct {
        logic       rst;
        logic       ren;
        int         w;
        logic       chk_fire;
        logic       fire;
        logic       empty;
        logic       ae;
        logic [3:0] level;
        logic       uf;
        logic [3:0] ptr;
        logic [2:0] addr;
    } vec_t;

    vec_t tbl [7];
    logic [3:0] drain_seq [8];

    function automatic logic [3:0] gray4(input int n);
        int m;
        m = n % 16;
        return 4'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check read_fire before the edge, advance the
    // model at the edge, then check all registered outputs.
    task automatic step(input logic rst, input logic ren);
        read_rst  = rst;
        read_en   = ren;
        write_ptr = gray4(w_count);
        #2;
        last_fire = read_fire;
        if (m_valid) chk("read_fire", 32'(read_fire), 32'(ren & ~m_empty));
        @(posedge read_clk);
        if (rst) begin
            m_r = 0; m_tmp = 0; m_ws = 0; m_level = 0;
            m_empty = 1'b1; m_uf = 1'b0; m_valid = 1'b1;
        end else begin
            m_uf = ren & m_empty;
            if (ren && !m_empty) m_r++;
            m_level = m_ws - m_r;
            m_empty = (m_level == 0);
            m_ws    = m_tmp;
            m_tmp   = w_count;
        end
        #1;
        if (m_valid) begin
            chk("empty", 32'(empty), 32'(m_empty));
            chk("almost_empty", 32'(almost_empty), 32'(m_level <= 1));
            chk("read_level", 32'(read_level), 32'(m_level % 16));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("read_ptr", 32'(read_ptr), 32'(gray4(m_r)));
            chk("read_addr", 32'(read_addr), 32'(m_r % 8));
        end
        $display("cyc t=%0t rst=%0b ren=%0b wp=%b fire=%0b ptr=%b lvl=%0d empty=%0b ae=%0b uf=%0b",
                 $time, rst, ren, write_ptr, last_fire, read_ptr, read_level, empty,
                 almost_empty, underflow);
    endtask

    initial begin
        int fires;
        read_rst  = 1'b1;
        read_en   = 1'b0;
        write_ptr = '0;

        //          rst   ren   w  chkf  fire  empty ae    lvl   uf    ptr      addr
        tbl[0] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0000, 3'd0};
        tbl[4] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0000, 3'd0};
        tbl[5] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 3'd1};
        tbl[6] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0001, 3'd1};

        drain_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                      4'b0111, 4'b0101, 4'b0100, 4'b1100};

        // Reset then a single write/read pair
        for (int i = 0; i < 7; i++) begin
            w_count = tbl[i].w;
            step(tbl[i].rst, tbl[i].ren);
            if (tbl[i].chk_fire) chk("tbl_fire", 32'(last_fire), 32'(tbl[i].fire));
            chk("tbl_empty", 32'(empty), 32'(tbl[i].empty));
            chk("tbl_ae", 32'(almost_empty), 32'(tbl[i].ae));
            chk("tbl_level", 32'(read_level), 32'(tbl[i].level));
            chk("tbl_uf", 32'(underflow), 32'(tbl[i].uf));
            chk("tbl_ptr", 32'(read_ptr), 32'(tbl[i].ptr));
            chk("tbl_addr", 32'(read_addr), 32'(tbl[i].addr));
        end

        // Full drain of 8 entries
        w_count = 0;
        step(1'b1, 1'b0);
        w_count = 8;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("drain_level", 32'(read_level), 32'd8);
        chk("drain_ae", 32'(almost_empty), 32'd0);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            if (last_fire) fires++;
            chk("drain_ptr", 32'(read_ptr), 32'(drain_seq[i]));
            chk("drain_ae_lvl", 32'(almost_empty), 32'(7 - i <= 1));
        end
        chk("drain_fires", 32'(fires), 32'd8);
        chk("drain_empty", 32'(empty), 32'd1);

        // Underflow: three read attempts while empty
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("uf_fire", 32'(last_fire), 32'd0);
            chk("uf_pulse", 32'(underflow), 32'd1);
            chk("uf_ptr", 32'(read_ptr), 32'b1100);
        end
        step(1'b0, 1'b0);
        chk("uf_clear", 32'(underflow), 32'd0);

        // Wrap: 20 write/read pairs carry the pointers through 15 -> 0
        for (int i = 0; i < 20; i++) begin
            w_count++;
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            chk("wrap_level", 32'(read_level), 32'd0);
            chk("wrap_empty", 32'(empty), 32'd1);
        end
        chk("wrap_ptr", 32'(read_ptr), 32'(gray4(28)));

        // Reset mid-operation with level 5 and read_en high
        w_count = 0;
        step(1'b1, 1'b0);
        w_count = 5;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("mid_level5", 32'(read_level), 32'd5);
        step(1'b1, 1'b1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_level", 32'(read_level), 32'd0);
        chk("mid_rst_ptr", 32'(read_ptr), 32'd0);
        chk("mid_rst_ae", 32'(almost_empty), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0);
            chk("mid_refill_empty", 32'(empty), 32'(i < 3));
            chk("mid_refill_level", 32'(read_level), (i < 3) ? 32'd0 : 32'd5);
        end

        // Randomised traffic with occasional joint reset
        for (int i = 0; i < 400; i++) begin
            logic r_rst;
            logic r_ren;
            r_rst = ($urandom_range(0, 63) == 0);
            r_ren = $urandom_range(0, 1) == 1;
            if (r_rst) begin
                w_count = 0;
            end else if ($urandom_range(0, 2) != 0 && (w_count - m_r) < 8) begin
                w_count++;
            end
            step(r_rst, r_ren);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
